// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared execute-stage enums, multiply/divide op encoding and helpers
package muldiv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    MD_MULTU = 2'd0,
    MD_DIVU  = 2'd1,
    MD_MULT  = 2'd2,
    MD_DIV   = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  // Cycles from the start sample to the done pulse: WIDTH RUN steps, one FIX, one commit.
  function automatic int md_latency(input int width);
    return width + 2;
  endfunction

  // Control-unit decode of the R-type funct field into a multiply/divide op.
  function automatic md_op_t funct_to_md_op(input logic [5:0] funct);
    return funct == FUNCT_MULTU ? MD_MULTU :
           funct == FUNCT_DIVU  ? MD_DIVU  :
           funct == FUNCT_MULT  ? MD_MULT  : MD_DIV;
  endfunction

endpackage

// File: rtl/muldiv_unit_md_step.sv
// md_step: one radix-2 shift-add (multiply) or restoring-subtract (divide) step
module md_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] opnd_n
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic           ge;

  // Multiply: add m when the multiplier LSB is set, then shift {carry, acc, opnd} right.
  assign sum = {1'b0, acc} + (opnd[0] ? {1'b0, m} : '0);
  // Divide: shift the next dividend bit into the partial remainder and try subtracting.
  assign sh  = {acc, opnd[WIDTH-1]};
  assign ge  = sh >= {1'b0, m};

  assign acc_n  = div ? (ge ? WIDTH'(sh - {1'b0, m}) : sh[WIDTH-1:0]) : sum[WIDTH:1];
  assign opnd_n = div ? {opnd[WIDTH-2:0], ge} : {sum[0], opnd[WIDTH-1:1]};

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU with HI/LO; signed ops need MULDIV_SIGNED_EN
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t          state, state_n;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc, opnd, m, a_raw;
  logic [WIDTH-1:0]   acc_n, opnd_n;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   q_s, r_s, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_s;
  logic               is_div, dz, accept, commit, op_div;

  assign op_div = (op == MD_DIVU) || (op == MD_DIV);
  assign busy   = state != IDLE;

  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;

  // Next state; flush beats start in IDLE and abandons RUN/FIX without committing.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        accept  = start && !flush;
        state_n = accept ? RUN : IDLE;
      end
      RUN:  state_n = flush ? IDLE : (cnt == '0 ? FIX : RUN);
      FIX: begin
        commit  = !flush;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  md_step #(.WIDTH(WIDTH)) u_step (
    .div   (is_div),
    .acc   (acc),
    .opnd  (opnd),
    .m     (m),
    .acc_n (acc_n),
    .opnd_n(opnd_n)
  );

`ifdef MULDIV_SIGNED_EN
  logic sa, sb, neg_q, neg_r;
  assign sa    = ((op == MD_MULT) || (op == MD_DIV)) && a[WIDTH-1];
  assign sb    = ((op == MD_MULT) || (op == MD_DIV)) && b[WIDTH-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;
  // Operand signs captured at start; FIX uses them to restore the result signs.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end
  assign prod_s = neg_q ? -{acc, opnd} : {acc, opnd};
  assign q_s    = neg_q ? -opnd : opnd;
  assign r_s    = neg_r ? -acc : acc;
`else
  assign mag_a  = a;
  assign mag_b  = b;
  assign prod_s = {acc, opnd};
  assign q_s    = opnd;
  assign r_s    = acc;
`endif

  // Divide-by-zero bypasses the iterated result so hi returns the raw dividend.
  assign res_hi = is_div ? (dz ? a_raw : r_s) : prod_s[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? (dz ? '1 : q_s) : prod_s[WIDTH-1:0];

  // Operand latch on start, then one step per RUN cycle with the counter running down.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      m      <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      dz     <= 1'b0;
    end else if (accept) begin
      cnt    <= CW'(WIDTH - 1);
      acc    <= '0;
      opnd   <= mag_a;
      m      <= mag_b;
      a_raw  <= a;
      is_div <= op_div;
      dz     <= op_div && (b == '0);
    end else if (state == RUN) begin
      cnt  <= cnt - 1'b1;
      acc  <= acc_n;
      opnd <= opnd_n;
    end

  // Architectural HI/LO and status change only when FIX exits without a flush.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= commit;
      if (commit) begin
        hi          <= res_hi;
        lo          <= res_lo;
        div_by_zero <= dz;
      end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  md_op_t       op = MD_MULTU;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  // Reference: plain integer arithmetic on the architectural operation.
  function automatic void model(input md_op_t o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output logic ez);
    logic s;
    logic [63:0] p;
    int sx, sy;
`ifdef MULDIV_SIGNED_EN
    s = (o == MD_MULT) || (o == MD_DIV);
`else
    s = 1'b0;
`endif
    ez = 1'b0;
    sx = x;
    sy = y;
    if (o == MD_MULTU || o == MD_MULT) begin
      if (s) p = 64'(longint'(sx) * longint'(sy));
      else   p = {32'b0, x} * {32'b0, y};
      eh = p[63:32];
      el = p[31:0];
    end else if (y == 0) begin
      eh = x; el = '1; ez = 1'b1;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      el = x; eh = '0;
    end else if (s) begin
      el = 32'(sx / sy);
      eh = 32'(sx % sy);
    end else begin
      el = x / y;
      eh = x % y;
    end
  endfunction

  function automatic logic [31:0] pick();
    int r;
    r = $urandom_range(0, 7);
    return r == 0 ? 32'h0 : r == 1 ? 32'h8000_0000 : r == 2 ? 32'hFFFF_FFFF : 32'($urandom);
  endfunction

  // Issue one op at the current negedge (cycle 0) and wait, bounded, for done.
  task automatic run(input md_op_t o, input logic [31:0] x, input logic [31:0] y,
                     output int lat, output int bc);
    int c;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = md_op_t'($urandom_range(0, 3));
    c = 1;
    bc = 0;
    while (!done && c < 200) begin
      if (busy) bc++;
      @(negedge clk);
      c++;
    end
    lat = done ? c : -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", div_by_zero); end
    checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu_max();
    int lat, bc;
    run(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL multu_latency got %0d want %0d", lat, LAT); end
    checks++; if (bc !== LAT - 1) begin errors++; $display("FAIL multu_busy_cycles got %0d want %0d", bc, LAT - 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got %b want 0", busy); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [31:0] x, y, eh, el;
    logic ez;
    run(MD_DIVU, 32'd100, 32'd7, lat, bc);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %0d want 14", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %0d want 2", hi); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL divu_dz got %b want 0", div_by_zero); end
    x = $urandom; y = $urandom_range(1, 1000);
    model(MD_DIVU, x, y, eh, el, ez);
    run(MD_DIVU, x, y, lat, bc);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
    checks++; if ({hi, lo} !== {eh, el}) begin errors++; $display("FAIL b2b_result got %h_%h want %h_%h", hi, lo, eh, el); end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    logic [31:0] eh, el;
    logic ez;
    run(MD_DIVU, 32'h1234, 32'h0, lat, bc);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL dz_latency got %0d want %0d", lat, LAT); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo got %h want ffffffff", lo); end
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL dz_hi got %h want 00001234", hi); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
    model(MD_DIV, 32'hFFFF_FF00, 32'h0, eh, el, ez);
    run(MD_DIV, 32'hFFFF_FF00, 32'h0, lat, bc);
    checks++; if ({div_by_zero, hi, lo} !== {ez, eh, el}) begin errors++; $display("FAIL dz_signed got %b %h %h want %b %h %h", div_by_zero, hi, lo, ez, eh, el); end
    @(negedge clk);
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_hold got %b want 1", div_by_zero); end
  endtask

  task automatic test_signed();
    int lat, bc;
`ifdef MULDIV_SIGNED_EN
    run(MD_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc);
    checks++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_neg7_2 got %h_%h want ffffffff_fffffffd", hi, lo); end
    run(MD_MULT, 32'hFFFF_FFFD, 32'd5, lat, bc);
    checks++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin errors++; $display("FAIL mult_neg3_5 got %h_%h want ffffffff_fffffff1", hi, lo); end
    run(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    checks++; if ({div_by_zero, hi, lo} !== {1'b0, 32'h0, 32'h8000_0000}) begin errors++; $display("FAIL div_min_m1 got %b %h %h want 0 0 80000000", div_by_zero, hi, lo); end
`else
    run(MD_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc);
    checks++; if ({hi, lo} !== {32'h1, 32'h7FFF_FFFC}) begin errors++; $display("FAIL div_unsigned got %h_%h want 00000001_7ffffffc", hi, lo); end
    run(MD_MULT, 32'hFFFF_FFFD, 32'd5, lat, bc);
    checks++; if ({hi, lo} !== {32'h4, 32'hFFFF_FFF1}) begin errors++; $display("FAIL mult_unsigned got %h_%h want 00000004_fffffff1", hi, lo); end
`endif
    checks++; if (lat !== LAT) begin errors++; $display("FAIL signed_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_random();
    int lat, bc;
    md_op_t o;
    logic [31:0] x, y, eh, el;
    logic ez;
    for (int i = 0; i < 60; i++) begin
      o = md_op_t'($urandom_range(0, 3));
      x = pick();
      y = pick();
      model(o, x, y, eh, el, ez);
      run(o, x, y, lat, bc);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, lat, LAT); end
      checks++;
      if ({div_by_zero, hi, lo} !== {ez, eh, el}) begin
        errors++;
        $display("FAIL rand_result[%0d] op %0d a %h b %h got %b %h %h want %b %h %h", i, o, x, y, div_by_zero, hi, lo, ez, eh, el);
      end
    end
  endtask

  task automatic test_flush();
    int lat, bc, bad;
    logic [31:0] ph, pl;
    run(MD_MULTU, $urandom | 32'h8000_0001, $urandom | 32'h8000_0001, lat, bc);
    ph = hi; pl = lo;
    start = 1'b1; op = MD_DIVU; a = $urandom; b = $urandom_range(1, 50);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = MD_MULTU; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %b want 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after got %b want 0", busy); end
    bad = 0;
    for (int c = 0; c < 45; c++) begin
      if (done || busy) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL flush_no_activity got %0d cycles want 0", bad); end
    checks++; if ({hi, lo} !== {ph, pl}) begin errors++; $display("FAIL flush_hold got %h_%h want %h_%h", hi, lo, ph, pl); end
    start = 1'b1; flush = 1'b1; op = MD_MULTU; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_flush_start got busy %b want 0", busy); end
  endtask

  task automatic test_async_reset();
    int lat, bc;
    run(MD_MULTU, $urandom | 32'h8000_0001, $urandom | 32'h8000_0001, lat, bc);
    start = 1'b1; op = MD_DIVU; a = $urandom; b = $urandom_range(1, 99);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", busy); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL async_hilo got %h_%h want 0_0", hi, lo); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL async_idle got %b%b want 00", busy, done); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_back_to_back();
    test_div_zero();
    test_signed();
    test_random();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
